// File: rtl/accel_matvec_q.sv
// accel_matvec_q: fixed-point matrix-vector accelerator.
// y[j] = sum_i x[i]*W[i][j]; W loaded over its own AXI4-Stream.
module accel_matvec_q #(
  parameter int ROWS   = 3,
  parameter int COLS   = 4,
  parameter int DATA_W = 32,
  parameter int FRAC_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] WEIGHT_AXIS_TDATA,
  input  logic              WEIGHT_AXIS_TLAST,
  input  logic              WEIGHT_AXIS_TVALID,
  output logic              WEIGHT_AXIS_TREADY,
  input  logic [DATA_W-1:0] INPUT_AXIS_TDATA,
  input  logic              INPUT_AXIS_TLAST,
  input  logic              INPUT_AXIS_TVALID,
  output logic              INPUT_AXIS_TREADY,
  output logic [DATA_W-1:0] OUTPUT_AXIS_TDATA,
  output logic              OUTPUT_AXIS_TLAST,
  output logic              OUTPUT_AXIS_TVALID,
  input  logic              OUTPUT_AXIS_TREADY,
  output logic              weights_loaded,
  output logic              weight_err
);
  localparam int ACC_W = 2*DATA_W + $clog2(ROWS+1);
  localparam int PW    = 2*DATA_W;
  localparam int NW    = ROWS*COLS;
  localparam int WW    = (NW > 1) ? $clog2(NW) : 1;
  localparam int IW    = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int CW    = (COLS > 1) ? $clog2(COLS) : 1;

  localparam logic signed [ACC_W-1:0] SMAX =
    {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SMIN =
    {{(ACC_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, ACCUM, EMIT} state_t;

  state_t state_q, state_d;
  logic [WW-1:0] w_idx_q, w_idx_d;
  logic [IW-1:0] in_idx_q, in_idx_d;
  logic [CW-1:0] out_idx_q, out_idx_d;
  logic wl_q, wl_d;
  logic err_q, err_d;
  logic w_rdy_q, w_rdy_d;
  logic in_rdy_q, in_rdy_d;
  logic signed [DATA_W-1:0] w_q [ROWS][COLS];
  logic signed [ACC_W-1:0] acc_q [COLS];
  logic signed [ACC_W-1:0] acc_d [COLS];
  logic signed [PW-1:0] prod [COLS];
  logic signed [ACC_W-1:0] sh;
  logic w_hs, in_hs, out_hs, w_last;
  logic unused_tlast;

  assign unused_tlast = INPUT_AXIS_TLAST;

  assign w_hs   = WEIGHT_AXIS_TVALID && w_rdy_q;
  assign in_hs  = INPUT_AXIS_TVALID && in_rdy_q;
  assign out_hs = OUTPUT_AXIS_TVALID && OUTPUT_AXIS_TREADY;
  assign w_last = (w_idx_q == WW'(NW-1));

  assign WEIGHT_AXIS_TREADY = w_rdy_q;
  assign INPUT_AXIS_TREADY  = in_rdy_q;
  assign OUTPUT_AXIS_TVALID = (state_q == EMIT);
  assign weights_loaded     = wl_q;
  assign weight_err         = err_q;

  always_comb begin
    for (int j = 0; j < COLS; j++) begin
      prod[j] = PW'($signed(INPUT_AXIS_TDATA))
              * PW'(w_q[in_idx_q][j]);
    end
  end

  always_comb begin
    sh = acc_q[out_idx_q] >>> FRAC_W;
    OUTPUT_AXIS_TDATA = '0;
    OUTPUT_AXIS_TLAST = 1'b0;
    if (state_q == EMIT) begin
      if (sh > SMAX) begin
        OUTPUT_AXIS_TDATA = {1'b0, {(DATA_W-1){1'b1}}};
      end else if (sh < SMIN) begin
        OUTPUT_AXIS_TDATA = {1'b1, {(DATA_W-1){1'b0}}};
      end else begin
        OUTPUT_AXIS_TDATA = sh[DATA_W-1:0];
      end
      OUTPUT_AXIS_TLAST = (out_idx_q == CW'(COLS-1));
    end
  end

  always_comb begin
    state_d   = state_q;
    w_idx_d   = w_idx_q;
    in_idx_d  = in_idx_q;
    out_idx_d = out_idx_q;
    wl_d      = wl_q;
    err_d     = err_q;
    acc_d     = acc_q;
    if (w_hs) begin
      w_idx_d = '0;
      wl_d    = 1'b0;
      if (w_last && WEIGHT_AXIS_TLAST) begin
        wl_d  = 1'b1;
        err_d = 1'b0;
      end else if (w_last || WEIGHT_AXIS_TLAST) begin
        err_d = 1'b1;
      end else begin
        w_idx_d = w_idx_q + 1'b1;
      end
    end
    unique case (state_q)
      IDLE, ACCUM: begin
        if (in_hs) begin
          for (int j = 0; j < COLS; j++) begin
            acc_d[j] = acc_q[j] + ACC_W'(prod[j]);
          end
          if (in_idx_q == IW'(ROWS-1)) begin
            in_idx_d = '0;
            state_d  = EMIT;
          end else begin
            in_idx_d = in_idx_q + 1'b1;
            state_d  = ACCUM;
          end
        end
      end
      EMIT: begin
        if (out_hs) begin
          if (out_idx_q == CW'(COLS-1)) begin
            out_idx_d = '0;
            state_d   = IDLE;
            for (int j = 0; j < COLS; j++) begin
              acc_d[j] = '0;
            end
          end else begin
            out_idx_d = out_idx_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    // ready flags are registered from the next state
    w_rdy_d  = (state_d == IDLE) && (in_idx_d == '0);
    in_rdy_d = wl_d && (state_d != EMIT);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      w_idx_q   <= '0;
      in_idx_q  <= '0;
      out_idx_q <= '0;
      wl_q      <= 1'b0;
      err_q     <= 1'b0;
      w_rdy_q   <= 1'b0;
      in_rdy_q  <= 1'b0;
      for (int j = 0; j < COLS; j++) begin
        acc_q[j] <= '0;
      end
      for (int r = 0; r < ROWS; r++) begin
        for (int c = 0; c < COLS; c++) begin
          w_q[r][c] <= '0;
        end
      end
    end else begin
      state_q   <= state_d;
      w_idx_q   <= w_idx_d;
      in_idx_q  <= in_idx_d;
      out_idx_q <= out_idx_d;
      wl_q      <= wl_d;
      err_q     <= err_d;
      w_rdy_q   <= w_rdy_d;
      in_rdy_q  <= in_rdy_d;
      acc_q     <= acc_d;
      if (w_hs) begin
        for (int r = 0; r < ROWS; r++) begin
          for (int c = 0; c < COLS; c++) begin
            if (w_idx_q == WW'(r*COLS+c)) begin
              w_q[r][c] <= WEIGHT_AXIS_TDATA;
            end
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_accel_matvec_q.sv
// tb_accel_matvec_q: table vectors, corner sequences and
// randomized vectors against an arithmetic reference model.
module tb_accel_matvec_q;
  localparam int R = 3;
  localparam int C = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [31:0] w_data = '0;
  logic w_last = 1'b0, w_valid = 1'b0;
  logic [31:0] x_data = '0;
  logic x_last = 1'b0, x_valid = 1'b0;
  logic out_rdy = 1'b0;
  logic w_rdy, x_rdy, y_last, y_valid, wl, werr;
  logic [31:0] y_data;

  int errs = 0;
  int checks = 0;
  int cyc = 0;
  int mw [R][C];

  typedef struct {
    int kind;
    logic [R-1:0][31:0] x;
    logic [C-1:0][31:0] y;
  } vec_t;
  vec_t tbl [8];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  accel_matvec_q #(.ROWS(R), .COLS(C), .DATA_W(32), .FRAC_W(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .WEIGHT_AXIS_TDATA(w_data), .WEIGHT_AXIS_TLAST(w_last),
    .WEIGHT_AXIS_TVALID(w_valid), .WEIGHT_AXIS_TREADY(w_rdy),
    .INPUT_AXIS_TDATA(x_data), .INPUT_AXIS_TLAST(x_last),
    .INPUT_AXIS_TVALID(x_valid), .INPUT_AXIS_TREADY(x_rdy),
    .OUTPUT_AXIS_TDATA(y_data), .OUTPUT_AXIS_TLAST(y_last),
    .OUTPUT_AXIS_TVALID(y_valid), .OUTPUT_AXIS_TREADY(out_rdy),
    .weights_loaded(wl), .weight_err(werr)
  );

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic vec_t mk(input int k,
    input logic [31:0] a0, a1, a2, b0, b1, b2, b3);
    vec_t t;
    t.kind = k;
    t.x[0] = a0; t.x[1] = a1; t.x[2] = a2;
    t.y[0] = b0; t.y[1] = b1; t.y[2] = b2; t.y[3] = b3;
    return t;
  endfunction

  function automatic logic [31:0] rnd();
    case ($urandom_range(0, 2))
      0: return $urandom();
      1: return 32'(int'($urandom_range(0, 1 << 20)) - (1 << 19));
      default: return 32'(int'($urandom_range(0, 8191)) - 4096);
    endcase
  endfunction

  function automatic logic [31:0] model(
    input logic [R-1:0][31:0] xv, input int j);
    logic signed [95:0] s, hi, lo;
    hi = 96'sd2147483647;
    lo = -96'sd2147483648;
    s = '0;
    for (int i = 0; i < R; i++) begin
      s += 96'($signed(xv[i])) * 96'(mw[i][j]);
    end
    s = s >>> 16;
    if (s > hi) return 32'h7FFFFFFF;
    if (s < lo) return 32'h80000000;
    return s[31:0];
  endfunction

  task automatic wsend(input logic [31:0] d, input logic l);
    int n;
    n = 0;
    w_data = d; w_last = l; w_valid = 1'b1;
    do begin
      @(negedge clk);
      n++;
    end while (!w_rdy && n < 200);
    if (!w_rdy) chk("weight tready timeout", 0, 1);
    @(posedge clk); #1;
    w_valid = 1'b0;
  endtask

  task automatic xsend(input logic [31:0] d, output int hc);
    int n;
    n = 0;
    x_data = d; x_valid = 1'b1;
    do begin
      @(negedge clk);
      n++;
    end while (!x_rdy && n < 200);
    if (!x_rdy) chk("input tready timeout", 0, 1);
    @(posedge clk); #1;
    hc = cyc;
    x_valid = 1'b0;
  endtask

  task automatic yrecv(output logic [31:0] d, output logic l,
                       output int vc);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!y_valid && n < 200);
    if (!y_valid) chk("output tvalid timeout", 0, 1);
    d = y_data; l = y_last; vc = cyc;
    out_rdy = 1'b1;
    @(posedge clk); #1;
    out_rdy = 1'b0;
  endtask

  task automatic load(input int kind);
    logic [31:0] v;
    for (int i = 0; i < R; i++) begin
      for (int j = 0; j < C; j++) begin
        if (kind == 0) v = 32'((i*C + j + 1) << 16);
        else if (kind == 1) v = 32'h7FFF0000;
        else v = rnd();
        mw[i][j] = int'(v);
        wsend(v, (i == R-1) && (j == C-1));
      end
    end
  endtask

  task automatic vec(input string nm, input logic [R-1:0][31:0] xv,
    input logic [C-1:0][31:0] ev, input int stall, input int nout,
    output int h0, output int h2, output int v0);
    logic [31:0] d, d0;
    logic l, l0;
    int hc, vc;
    h0 = 0; h2 = 0; v0 = 0;
    for (int i = 0; i < R; i++) begin
      xsend(xv[i], hc);
      if (i == 0) h0 = hc;
      if (i == R-2) chk({nm, " early tvalid"}, y_valid, 0);
    end
    h2 = hc;
    if (stall > 0) begin
      @(negedge clk);
      d0 = y_data; l0 = y_last;
      chk({nm, " stall y0"}, d0, ev[0]);
      for (int s = 0; s < stall; s++) begin
        @(negedge clk);
        chk({nm, " stall tvalid"}, y_valid, 1);
        chk({nm, " stall tdata"}, y_data, d0);
        chk({nm, " stall tlast"}, y_last, l0);
        chk({nm, " stall in tready"}, x_rdy, 0);
      end
    end
    for (int j = 0; j < nout; j++) begin
      yrecv(d, l, vc);
      if (j == 0) v0 = vc;
      chk($sformatf("%s y%0d", nm, j), d, ev[j]);
      chk($sformatf("%s tlast%0d", nm, j), l, (j == C-1));
    end
  endtask

  initial begin
    int h0, h2, v0, h0b, bad, cur;
    logic [R-1:0][31:0] xv;
    logic [C-1:0][31:0] ev;

    tbl[0] = mk(0, 32'h00008000, 32'h00010000, 32'h00018000,
      32'h00130000, 32'h00160000, 32'h00190000, 32'h001C0000);
    tbl[1] = mk(0, 32'hFFFF0000, 32'h0, 32'h0,
      32'hFFFF0000, 32'hFFFE0000, 32'hFFFD0000, 32'hFFFC0000);
    tbl[2] = mk(0, 32'h00010000, 32'h0, 32'h0,
      32'h00010000, 32'h00020000, 32'h00030000, 32'h00040000);
    tbl[3] = mk(0, 32'h0, 32'h0, 32'h00010000,
      32'h00090000, 32'h000A0000, 32'h000B0000, 32'h000C0000);
    tbl[4] = mk(0, 32'hFFFFFFFF, 32'h0, 32'h0,
      32'hFFFFFFFF, 32'hFFFFFFFE, 32'hFFFFFFFD, 32'hFFFFFFFC);
    tbl[5] = mk(0, 32'h0, 32'h00000001, 32'h0,
      32'h00000005, 32'h00000006, 32'h00000007, 32'h00000008);
    tbl[6] = mk(1, 32'h7FFF0000, 32'h7FFF0000, 32'h7FFF0000,
      32'h7FFFFFFF, 32'h7FFFFFFF, 32'h7FFFFFFF, 32'h7FFFFFFF);
    tbl[7] = mk(1, 32'h80010000, 32'h80010000, 32'h80010000,
      32'h80000000, 32'h80000000, 32'h80000000, 32'h80000000);

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst tvalid", y_valid, 0);
    chk("rst tlast", y_last, 0);
    chk("rst tdata", y_data, 0);
    chk("rst loaded", wl, 0);
    chk("rst err", werr, 0);
    chk("rst w tready", w_rdy, 0);
    chk("rst in tready", x_rdy, 0);
    rst_n = 1'b1;

    bad = 0;
    x_valid = 1'b1;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (x_rdy) bad++;
    end
    x_valid = 1'b0;
    chk("no-weight in tready", bad, 0);
    chk("idle w tready", w_rdy, 1);

    for (int k = 0; k < 5; k++) wsend(32'(k), k == 4);
    chk("bad frame err", werr, 1);
    chk("bad frame loaded", wl, 0);
    load(0);
    chk("good frame err", werr, 0);
    chk("good frame loaded", wl, 1);

    vec("basic", tbl[0].x, tbl[0].y, 0, C, h0, h2, v0);
    chk("latency", v0 - h2, 0);

    cur = 0;
    for (int t = 0; t < 8; t++) begin
      if (tbl[t].kind != cur) begin
        load(tbl[t].kind);
        cur = tbl[t].kind;
      end
      vec($sformatf("tbl%0d", t), tbl[t].x, tbl[t].y, 0, C,
          h0, h2, v0);
    end

    load(0);
    vec("backpressure", tbl[0].x, tbl[0].y, 5, C, h0, h2, v0);
    vec("b2b A", tbl[0].x, tbl[0].y, 0, C, h0, h2, v0);
    vec("b2b B", tbl[2].x, tbl[2].y, 0, C, h0b, h2, v0);
    chk("b2b period", h0b - h0, R + C);

    vec("mid-reset", tbl[0].x, tbl[0].y, 0, 2, h0, h2, v0);
    rst_n = 1'b0;
    #1;
    chk("async rst tvalid", y_valid, 0);
    chk("async rst loaded", wl, 0);
    chk("async rst in tready", x_rdy, 0);
    @(negedge clk);
    rst_n = 1'b1;
    load(0);
    vec("after reset", tbl[0].x, tbl[0].y, 0, C, h0, h2, v0);

    for (int m = 0; m < 3; m++) begin
      load(2);
      for (int v = 0; v < 8; v++) begin
        for (int i = 0; i < R; i++) xv[i] = rnd();
        for (int j = 0; j < C; j++) ev[j] = model(xv, j);
        vec($sformatf("rand%0d.%0d", m, v), xv, ev,
            (v == 3) ? 2 : 0, C, h0, h2, v0);
      end
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule

// File: doc/accel_matvec_q.md
# accel_matvec_q

Parametrised fixed-point matrix-vector accelerator, successor to the fixed-size dot-product block. It computes y[j] = sum over i of x[i]·W[i][j] for a ROWS-element input vector and a ROWS×COLS weight matrix, producing a COLS-element output vector. Weights are loaded at runtime over their own AXI4-Stream instead of being a static port. It sits between the DMA input stream and the DMA output stream, and processes any number of vectors back-to-back with one loaded matrix.

## Interface
- ROWS, 3, input vector length (≥1)
- COLS, 4, output vector length (≥1)
- DATA_W, 32, signed two's-complement word width of x, W, y
- FRAC_W, 16, fractional bits; x, W, y are Q(DATA_W-FRAC_W).FRAC_W
- ACC_W (localparam), 2·DATA_W + $clog2(ROWS+1), accumulator width

- clk  in  1  sole clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- WEIGHT_AXIS_TDATA  in  DATA_W  weight word, row-major order (W[0][0], W[0][1], …)
- WEIGHT_AXIS_TLAST  in  1  marks word ROWS·COLS-1
- WEIGHT_AXIS_TVALID  in  1  weight word valid
- WEIGHT_AXIS_TREADY  out  1  weight word accepted
- INPUT_AXIS_TDATA  in  DATA_W  x[i]
- INPUT_AXIS_TLAST  in  1  ignored; framing is by count
- INPUT_AXIS_TVALID  in  1
- INPUT_AXIS_TREADY  out  1
- OUTPUT_AXIS_TDATA  out  DATA_W  y[j]
- OUTPUT_AXIS_TLAST  out  1  high with y[COLS-1]
- OUTPUT_AXIS_TVALID  out  1
- OUTPUT_AXIS_TREADY  in  1
- weights_loaded  out  1  full matrix resident
- weight_err  out  1  sticky; last weight frame had a misplaced TLAST

## Operation
- The FSM has three states: IDLE, ACCUM, EMIT.
- Weight load:
  - WEIGHT_AXIS_TREADY = 1 only in IDLE with in_idx = 0.
  - Each handshake writes the word to W[w_idx/COLS][w_idx%COLS] and increments w_idx.
  - The first weight handshake of a frame clears weights_loaded.
  - At w_idx = ROWS·COLS-1 with TLAST=1: set weights_loaded=1, clear weight_err, set w_idx=0.
  - If TLAST=1 at any other index, or TLAST=0 at the final index: set weight_err=1, keep weights_loaded=0, set w_idx=0.
- Input:
  - INPUT_AXIS_TREADY = weights_loaded in IDLE and ACCUM; 0 in EMIT.
  - A handshake with x = x[in_idx] does acc[j] += sext(x·W[in_idx][j]) for all j in the same cycle (COLS parallel full-width signed multipliers), then increments in_idx.
  - The first handshake moves IDLE→ACCUM.
  - The handshake at in_idx = ROWS-1 sets in_idx=0 and moves to EMIT (IDLE→EMIT directly when ROWS=1).
- Output:
  - In EMIT, TVALID=1 and TDATA = sat_DATA_W(acc[out_idx] >>> FRAC_W).
  - The shift is arithmetic, which truncates toward −∞.
  - Saturation is to [−2^(DATA_W-1), 2^(DATA_W-1)-1].
  - TLAST = (out_idx == COLS-1).
  - On a handshake out_idx increments. After the last handshake, all acc and out_idx clear and the FSM goes to IDLE.
- ACC_W is chosen so accumulation never overflows internally; saturation is applied only at output.

## Timing
- Reset (async assert, sync deassert):
  - FSM=IDLE; all counters 0; acc and W 0.
  - weights_loaded=0, weight_err=0.
  - All TREADY=0, OUTPUT_AXIS_TVALID=0, TLAST=0, TDATA=0.
- Reset asserted mid-operation (any state) aborts immediately to the reset state. The matrix must be reloaded.
- Handshake occurs on a rising edge with VALID&&READY. The block holds OUTPUT TDATA/TLAST stable while TVALID=1 and TREADY=0.
- Latency: OUTPUT_AXIS_TVALID rises the cycle after the final input handshake.
- Throughput: ROWS + COLS cycles per vector at full rate. The next vector's first input is accepted the cycle after the TLAST output handshake.
- TREADY outputs are registered from state and do not depend combinationally on TVALID inputs.
- Weight and input streams are never both ready in the same cycle once a vector is in progress. Weights cannot change mid-vector.

## Test plan
- Load weights 1.0…12.0 (0x00010000…0x000C0000, ROWS=3, COLS=4), then send x = 0x00008000, 0x00010000, 0x00018000.
  - Expected y = 0x00130000, 0x00160000, 0x00190000, 0x001C0000, TLAST on the 4th word.
  - Expected first TVALID exactly 1 cycle after the 3rd input handshake.
- Same weights, x = 0xFFFF0000, 0, 0.
  - Expected y = 0xFFFF0000, 0xFFFE0000, 0xFFFD0000, 0xFFFC0000.
- All W = 0x7FFF0000, all x = 0x7FFF0000.
  - Expected every y = 0x7FFFFFFF.
  - Negating x gives every y = 0x80000000.
- Behaviour before any load and on a bad frame:
  - After reset with no weights, INPUT_AXIS_TREADY stays 0 for 50 cycles.
  - Weight frame with TLAST on word 5: expect weight_err=1, weights_loaded=0.
  - A following good frame: expect weight_err=0, weights_loaded=1.
- Backpressure: hold OUTPUT_AXIS_TREADY=0 for 5 cycles during EMIT.
  - TVALID stays 1, TDATA and TLAST stay constant, INPUT_AXIS_TREADY=0, all 4 results still correct.
  - Then run two back-to-back vectors at full rate: 7 cycles per vector.
- Drop rst_n after the 2nd output handshake.
  - Expected: TVALID=0 and weights_loaded=0 without waiting for a clock edge.
  - After reload, the first scenario passes again.
